// File: rtl/bool_arbiter_if.sv
// bool_arbiter_if: bundles the two request channels, the shared BOOL unit
// bus, the response channel and the operation counter of bool_arbiter.
//   slave  : arbiter side (drives readys, BOOL inputs, response, count)
//   master : environment side (requesters, BOOL unit, response consumer)
interface bool_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_bfn;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_bfn;
  logic             req1_ready;

  logic [WIDTH-1:0] ba;
  logic [WIDTH-1:0] bb;
  logic [3:0]       bbfn;
  logic [WIDTH-1:0] boolo;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_ready;

  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_bfn,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_bfn,
    output req1_ready,
    output ba, bb, bbfn,
    input  boolo,
    output rsp_valid, rsp_id, rsp_data, rsp_zero,
    input  rsp_ready,
    output op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_bfn,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_bfn,
    input  req1_ready,
    input  ba, bb, bbfn,
    output boolo,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero,
    output rsp_ready,
    input  op_count
  );
endinterface

// File: rtl/bool_arbiter.sv
// bool_arbiter: two-requester round-robin arbiter in front of a shared
// combinational BOOL unit, with a single-entry tagged result register.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : bool_arbiter_if.slave (requests, BOOL bus, response, op count)
//
// state | meaning
// EMPTY | result register free, rsp_valid = 0
// FULL  | result register holds a result, rsp_valid = 1
module bool_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  bool_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic acc;
  logic gnt_valid;
  logic gnt_id;
  logic hs;
  logic drain;

  // Round robin: on contention the requester that did not win last time goes.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // A result being taken this cycle frees the register for a new one.
  assign acc   = (state_q == EMPTY) | bus.rsp_ready;
  assign drain = (state_q == FULL) & bus.rsp_ready;

  assign bus.req0_ready = ~rst_i & acc & gnt_valid & ~gnt_id;
  assign bus.req1_ready = ~rst_i & acc & gnt_valid &  gnt_id;
  assign hs             = bus.req0_ready | bus.req1_ready;

  always_comb begin
    bus.ba   = '0;
    bus.bb   = '0;
    bus.bbfn = '0;
    if (gnt_valid) begin
      bus.ba   = gnt_id ? bus.req1_a   : bus.req0_a;
      bus.bb   = gnt_id ? bus.req1_b   : bus.req0_b;
      bus.bbfn = gnt_id ? bus.req1_bfn : bus.req0_bfn;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rsp_id_d   = rsp_id_q;
    rsp_zero_d = rsp_zero_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, drain};
    case (state_q)
      EMPTY: begin
        if (hs) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.rsp_ready && !hs) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (hs) begin
      rsp_data_d = bus.boolo;
      rsp_zero_d = (bus.boolo == '0);
      rsp_id_d   = gnt_id;
      last_d     = gnt_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      last_q     <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_id_q   <= rsp_id_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: doc/bool_arbiter.md
Name: bool_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit BOOL unit of the BETA ALU.
- Accepts operation requests (A, B, BFN) from two independent sources over valid/ready handshakes and drives the shared BOOL unit's inputs from the winner.
- Captures BOOLO into a single-entry result register and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between the execute-stage issue logic and the external combinational BOOL instance.

Parameters:
- WIDTH, 32, datapath width of A, B and result.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an operation pending.
- REQ0_A  input  WIDTH  requester 0 operand A.
- REQ0_B  input  WIDTH  requester 0 operand B.
- REQ0_BFN  input  4  requester 0 truth-table function code.
- REQ0_READY  output  1  requester 0 operation accepted this cycle.
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_BFN, REQ1_READY  same as requester 0, for requester 1.
- BA  output  WIDTH  to shared BOOL unit A.
- BB  output  WIDTH  to shared BOOL unit B.
- BBFN  output  4  to shared BOOL unit BFN.
- BOOLO  input  WIDTH  combinational result from shared BOOL unit.
- RSP_VALID  output  1  result register holds a valid result.
- RSP_ID  output  1  requester that issued the held result.
- RSP_DATA  output  WIDTH  held result.
- RSP_ZERO  output  1  held result equals 0.
- RSP_READY  input  1  consumer takes the result.
- OP_COUNT  output  CNT_W  completed (handed-off) operations, wraps modulo 2^CNT_W.

Behaviour:
- Shared BOOL unit semantics: result bit i = BFN[{B[i],A[i]}]. Examples: 1000 = AND, 1110 = OR, 0110 = XOR, 1010 = A. All 16 codes are legal; the block passes BFN through unmodified.
- Two states, derived from RSP_VALID:
  - EMPTY (RSP_VALID=0).
  - FULL (RSP_VALID=1).
- Accept enable: ACC = ~RSP_VALID | RSP_READY. Draining and refilling in the same cycle gives 1 op/cycle throughput.
- Grant (combinational):
  - Only one valid requester: grant to it.
  - Both valid: grant to the requester != LAST.
  - None valid: no grant.
- REQx_READY = ACC & grant==x. At most one READY is high per cycle. A requester must hold VALID and its operands stable until it sees READY.
- BA/BB/BBFN carry the granted requester's fields, muxed combinationally. With no grant they are driven to 0.
- On a cycle with a handshake (REQx_VALID & REQx_READY), at the rising edge:
  - RSP_DATA <= BOOLO; RSP_ZERO <= (BOOLO==0); RSP_ID <= x; RSP_VALID <= 1; LAST <= x.
- On a cycle with RSP_VALID & RSP_READY and no new accept:
  - RSP_VALID <= 0.
  - RSP_DATA, RSP_ID and RSP_ZERO hold their last values.
- OP_COUNT increments by 1 on each RSP_VALID & RSP_READY cycle. It wraps from 2^CNT_W-1 to 0.
- Latency: 1 cycle from handshake to RSP_VALID.
- In FULL with RSP_READY=0:
  - Both READYs are 0.
  - RSP_* outputs stay stable.
  - LAST is unchanged.
- Reset values (RESET=1 at rising edge, takes priority over everything):
  - RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ZERO=0, OP_COUNT=0.
  - LAST=1, so requester 0 wins the first contention.
- Reset mid-operation: a pending result is discarded. Requester handshakes in the reset cycle are not accepted; REQx_READY is forced to 0 while RESET=1.
- No X propagation: all outputs are defined every cycle after the first reset.

Test Plan:
- After reset, REQ0_VALID=1, A=F0008001, B=20008002, BFN=1000 -> REQ0_READY=1 in that cycle. Next cycle RSP_VALID=1, RSP_ID=0, RSP_DATA=20008000, RSP_ZERO=0.
- Both valid in the same cycle, same A/B: REQ0 BFN=0110, REQ1 BFN=1110, RSP_READY=1 held high:
  - Cycle 1 grants REQ0, giving D0000003 (ID 0).
  - Cycle 2 grants REQ1, giving F0008003 (ID 1).
  - Throughput is 1 op/cycle.
- Backpressure: RSP_READY=0 for 5 cycles with REQ1 valid (BFN=1010):
  - RSP holds F0008001 / ID 1.
  - Both READYs stay 0.
  - On RSP_READY=1 the next op is accepted in the same cycle.
- Zero flag: A=0000FFFF, B=FFFF0000, BFN=1000 -> RSP_DATA=00000000, RSP_ZERO=1.
- Fairness: both valid continuously for 8 accepts -> RSP_ID alternates 0,1,0,1,...; OP_COUNT=8 after 8 consumed results.
- Reset mid-operation: assert RESET while FULL with RSP_READY=0 -> next cycle RSP_VALID=0, OP_COUNT=0. On the next contention REQ0 wins.
